lobster_fetch_queue: RTL and testbench

Instruction prefetch stage sitting directly upstream of the lobster128 executor. It issues sequential 64-bit bundle reads to the SRAM port and buffers the returned bundles in a small FIFO. It presents them to the decoder/executor with a valid/ready handshake, and flushes and restarts fetching on a redirect (branch, PC write, task switch).

---
 rtl/lobster_fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_lobster_fetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lobster_fetch_queue.sv
// Sequential 64-bit bundle prefetcher feeding the lobster128 executor through a small FIFO.
// Define LOBSTER_FETCH_PERF_EN to build the perf_fetched/perf_stall counters and ports.
//
//   state  | meaning
//   IDLE   | no request outstanding; issue when the FIFO has room
//   REQ    | request outstanding; its data will be pushed
//   DROP   | request orphaned by a redirect; its data will be discarded
module lobster_fetch_queue #(
  parameter int                    ADDR_WIDTH = 36,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 36'hF800
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_ce,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rdy,
  input  logic [63:0]           mem_data,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc
`ifdef LOBSTER_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t                  state_q;
  logic                    mem_ce_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q;

  logic [63:0]             inst_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_q   [DEPTH];
  logic [PW-1:0]           head_q, tail_q;
  logic [CW-1:0]           count_q, count_d, count_sp;

  logic                    push, pop, space;
  logic [ADDR_WIDTH-1:0]   redir_pc_al, fetch_pc_inc;
  logic                    unused_redir_lsb;

  assign redir_pc_al      = {redir_pc[ADDR_WIDTH-1:3], 3'b000};
  assign unused_redir_lsb = ^redir_pc[2:0];
  assign fetch_pc_inc     = fetch_pc_q + ADDR_WIDTH'(8);

  assign push     = (state_q == S_REQ) && mem_rdy && !redir_valid;
  assign pop      = out_ready && (count_q != '0) && !redir_valid;
  // Occupancy after this cycle's push/pop; issuing only below DEPTH reserves a slot for the in-flight bundle.
  assign count_sp = count_q + CW'(push) - CW'(pop);
  assign space    = count_sp < DEPTH_C;
  assign count_d  = redir_valid ? '0 : count_sp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_ce_q   <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redir_valid) begin
            fetch_pc_q <= redir_pc_al;
          end else if (space) begin
            mem_ce_q   <= 1'b1;
            mem_addr_q <= fetch_pc_q;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (redir_valid) begin
            fetch_pc_q <= redir_pc_al;
            if (mem_rdy) begin
              mem_ce_q <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              state_q  <= S_DROP;
            end
          end else if (mem_rdy) begin
            fetch_pc_q <= fetch_pc_inc;
            if (space) begin
              mem_addr_q <= fetch_pc_inc;
            end else begin
              mem_ce_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (redir_valid) fetch_pc_q <= redir_pc_al;
          if (mem_rdy) begin
            mem_ce_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          mem_ce_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      if (redir_valid) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) begin
          inst_q[tail_q] <= mem_data;
          pc_q[tail_q]   <= mem_addr_q;
          tail_q         <= tail_q + PW'(1);
        end
        if (pop) head_q <= head_q + PW'(1);
      end
    end
  end

  assign mem_ce    = mem_ce_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = (count_q != '0);
  assign out_inst  = inst_q[head_q];
  assign out_pc    = pc_q[head_q];

`ifdef LOBSTER_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (out_ready && !out_valid) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_lobster_fetch_queue.sv
// Randomized self-checking bench for lobster_fetch_queue against a sequential-fetch reference model.
module tb_lobster_fetch_queue;
  localparam int            AW    = 36;
  localparam int            DEPTH = 4;
  localparam logic [AW-1:0] RPC   = 36'hF800;

  logic          clk = 1'b0;
  logic          rst, mem_ce, mem_rdy, redir_valid, out_valid, out_ready;
  logic [AW-1:0] mem_addr, redir_pc, out_pc;
  logic [63:0]   mem_data, out_inst;
`ifdef LOBSTER_FETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_stall;
`endif

  int checks = 0;
  int failures = 0;

  bit            sram_active;
  int            sram_wait;
  logic [AW-1:0] sram_addr;
  int            lat_lo, lat_hi;

  lobster_fetch_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_data(mem_data),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
`ifdef LOBSTER_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
    return {a[27:0] ^ 28'h5A5C3E1, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SRAM model: answers each request after a random latency in [lat_lo, lat_hi].
  task automatic sram_step();
    if (!mem_ce) begin
      mem_rdy = 1'b0;
      sram_active = 1'b0;
    end else begin
      if (!sram_active) begin
        sram_active = 1'b1;
        sram_addr = mem_addr;
        sram_wait = int'($urandom_range(lat_hi, lat_lo)) - 1;
      end
      if (sram_wait == 0) begin
        mem_rdy = 1'b1;
        mem_data = mem_word(mem_addr);
        sram_active = 1'b0;
      end else begin
        mem_rdy = 1'b0;
        sram_wait--;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; redir_valid = 1'b0; redir_pc = '0; out_ready = 1'b0;
    mem_rdy = 1'b0; mem_data = '0;
    sram_active = 1'b0; sram_wait = 0; lat_lo = 1; lat_hi = 1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    checks++; if (mem_ce !== 1'b1 || mem_addr !== RPC) begin failures++; $display("FAIL reset_first_req ce=%b addr=%h want ce=1 addr=%h", mem_ce, mem_addr, RPC); end
    mem_rdy = 1'b1; mem_data = mem_word(RPC);
    tick();
    mem_rdy = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL reset_prefill out_valid=%b want 1", out_valid); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b want 0", mem_ce); end
    checks++; if (mem_addr !== RPC) begin failures++; $display("FAIL reset_addr got=%h want %h", mem_addr, RPC); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want 0", out_valid); end
    checks++; if (out_inst !== 64'h0 || out_pc !== '0) begin failures++; $display("FAIL reset_out_data inst=%h pc=%h want 0", out_inst, out_pc); end
    rst = 1'b0;
    tick();
    checks++; if (mem_ce !== 1'b1 || mem_addr !== RPC) begin failures++; $display("FAIL reset_restart ce=%b addr=%h want ce=1 addr=%h", mem_ce, mem_addr, RPC); end
  endtask

  task automatic test_stream();
    logic [AW-1:0] exp_req, exp_out;
    apply_reset();
    out_ready = 1'b1; exp_req = RPC; exp_out = RPC;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (mem_ce !== 1'b1 || mem_addr !== exp_req) begin failures++; $display("FAIL stream_req cyc=%0d ce=%b addr=%h want ce=1 addr=%h", i, mem_ce, mem_addr, exp_req); end
      checks++; if (out_valid !== ((i > 0) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", i, out_valid, (i > 0)); end
      if (i > 0) begin
        checks++; if (out_pc !== exp_out || out_inst !== mem_word(exp_out)) begin failures++; $display("FAIL stream_data cyc=%0d pc=%h inst=%h want pc=%h inst=%h", i, out_pc, out_inst, exp_out, mem_word(exp_out)); end
      end
      sram_step();
      if (mem_rdy) exp_req += 8;
      if (out_valid && out_ready) exp_out += 8;
    end
    mem_rdy = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_fill();
    int issues;
    apply_reset();
    issues = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_ce && !sram_active) issues++;
      sram_step();
    end
    checks++; if (issues != DEPTH) begin failures++; $display("FAIL fill_issues got=%0d want %0d", issues, DEPTH); end
    checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL fill_ce_idle got=%b want 0", mem_ce); end
    checks++; if (out_valid !== 1'b1 || out_pc !== RPC) begin failures++; $display("FAIL fill_head valid=%b pc=%h want 1 %h", out_valid, out_pc, RPC); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (mem_ce !== 1'b1 || mem_addr !== RPC + 36'd32) begin failures++; $display("FAIL fill_refetch ce=%b addr=%h want ce=1 addr=%h", mem_ce, mem_addr, RPC + 36'd32); end
    checks++; if (out_pc !== RPC + 36'd8) begin failures++; $display("FAIL fill_pop_head got=%h want %h", out_pc, RPC + 36'd8); end
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_ce && !sram_active) issues++;
      sram_step();
      tick();
    end
    checks++; if (issues != 1) begin failures++; $display("FAIL fill_one_refetch got=%0d want 1", issues); end
    checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL fill_ce_after got=%b want 0", mem_ce); end
  endtask

  task automatic test_redirect_stall();
    apply_reset();
    out_ready = 1'b1;
    tick();
    tick();
    redir_valid = 1'b1; redir_pc = 36'h1003;
    for (int i = 0; i < 4; i++) begin
      tick();
      redir_valid = 1'b0;
      checks++; if (mem_ce !== 1'b1 || mem_addr !== RPC || out_valid !== 1'b0) begin failures++; $display("FAIL drop_hold cyc=%0d ce=%b addr=%h valid=%b want 1 %h 0", i, mem_ce, mem_addr, out_valid, RPC); end
    end
    mem_rdy = 1'b1; mem_data = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mem_rdy = 1'b0;
    checks++; if (mem_ce !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL drop_gap ce=%b valid=%b want 0 0", mem_ce, out_valid); end
    tick();
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 36'h1000 || out_valid !== 1'b0) begin failures++; $display("FAIL drop_newreq ce=%b addr=%h valid=%b want 1 1000 0", mem_ce, mem_addr, out_valid); end
    mem_rdy = 1'b1; mem_data = mem_word(36'h1000);
    tick();
    mem_rdy = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 36'h1000 || out_inst !== mem_word(36'h1000)) begin failures++; $display("FAIL drop_deliver valid=%b pc=%h inst=%h want 1 1000 %h", out_valid, out_pc, out_inst, mem_word(36'h1000)); end
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 36'h1008) begin failures++; $display("FAIL drop_next ce=%b addr=%h want 1 1008", mem_ce, mem_addr); end
  endtask

  task automatic test_redirect_same_cycle();
    logic [AW-1:0] rp, rp_al;
    rp = {4'($urandom_range(15, 0)), 32'($urandom)};
    rp_al = {rp[AW-1:3], 3'b000};
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      mem_rdy = 1'b1; mem_data = mem_word(mem_addr);
    end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== RPC || mem_addr !== RPC + 36'd16) begin failures++; $display("FAIL same_setup valid=%b pc=%h addr=%h want 1 %h %h", out_valid, out_pc, mem_addr, RPC, RPC + 36'd16); end
    mem_rdy = 1'b1; mem_data = mem_word(mem_addr); out_ready = 1'b1;
    redir_valid = 1'b1; redir_pc = rp;
    tick();
    mem_rdy = 1'b0; redir_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || mem_ce !== 1'b0) begin failures++; $display("FAIL same_flush valid=%b ce=%b want 0 0", out_valid, mem_ce); end
    tick();
    checks++; if (mem_ce !== 1'b1 || mem_addr !== rp_al || out_valid !== 1'b0) begin failures++; $display("FAIL same_newreq ce=%b addr=%h valid=%b want 1 %h 0", mem_ce, mem_addr, out_valid, rp_al); end
    mem_rdy = 1'b1; mem_data = mem_word(rp_al);
    tick();
    mem_rdy = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== rp_al || out_inst !== mem_word(rp_al)) begin failures++; $display("FAIL same_deliver valid=%b pc=%h inst=%h want 1 %h %h", out_valid, out_pc, out_inst, rp_al, mem_word(rp_al)); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_req, exp_out, want_addr;
    int occ, delivered, cyc;
    apply_reset();
    lat_lo = 1; lat_hi = 4;
    exp_req = RPC; exp_out = RPC; occ = 0; delivered = 0; cyc = 0;
    while (delivered < 200 && cyc < 6000) begin
      tick();
      cyc++;
      if (mem_ce) begin
        want_addr = sram_active ? sram_addr : exp_req;
        checks++; if (mem_addr !== want_addr) begin failures++; $display("FAIL rand_req cyc=%0d addr=%h want %h", cyc, mem_addr, want_addr); end
      end
      checks++; if (out_valid !== (occ != 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", cyc, out_valid, (occ != 0)); end
      if (out_valid) begin
        checks++; if (out_pc !== exp_out || out_inst !== mem_word(exp_out)) begin failures++; $display("FAIL rand_data cyc=%0d pc=%h inst=%h want pc=%h inst=%h", cyc, out_pc, out_inst, exp_out, mem_word(exp_out)); end
      end
      out_ready = 1'($urandom_range(1, 0));
      sram_step();
      if (mem_rdy) begin occ++; exp_req += 8; end
      if (out_valid && out_ready) begin occ--; exp_out += 8; delivered++; end
    end
    checks++; if (delivered < 200) begin failures++; $display("FAIL rand_timeout delivered=%0d want 200", delivered); end
    out_ready = 1'b0; mem_rdy = 1'b0;
  endtask

`ifdef LOBSTER_FETCH_PERF_EN
  task automatic test_perf();
    int fe, st;
    rst = 1'b1; redir_valid = 1'b0; out_ready = 1'b1; mem_rdy = 1'b0;
    sram_active = 1'b0; lat_lo = 1; lat_hi = 3;
    repeat (3) tick();
    checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin failures++; $display("FAIL perf_reset fetched=%0d stall=%0d want 0 0", perf_fetched, perf_stall); end
    rst = 1'b0;
    fe = 0; st = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_ready && !out_valid) st++;
      if (mem_rdy) fe++;
      tick();
      out_ready = 1'($urandom_range(1, 0));
      sram_step();
    end
    checks++; if (perf_fetched !== 32'(fe)) begin failures++; $display("FAIL perf_fetched got=%0d want %0d", perf_fetched, fe); end
    checks++; if (perf_stall !== 32'(st)) begin failures++; $display("FAIL perf_stall got=%0d want %0d", perf_stall, st); end
    out_ready = 1'b0; mem_rdy = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; redir_valid = 1'b0; redir_pc = '0; out_ready = 1'b0;
    mem_rdy = 1'b0; mem_data = '0;
    test_reset();
    test_stream();
    test_fill();
    test_redirect_stall();
    test_redirect_same_cycle();
    test_random();
`ifdef LOBSTER_FETCH_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
